// File: rtl/config_frame_writer_if.sv
// Configuration word input and column frame-select output bundle.
// The loader/bench side uses master; the frame writer uses slave.
interface config_frame_writer_if #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5,
    parameter int FrameBitsPerRow  = 32
);
    logic [31:0]                 WriteData;
    logic                        WriteStrobe;
    logic [FrameBitsPerRow-1:0]  FrameData;
    logic [MaxFramesPerCol-1:0]  FrameStrobe_O;
    logic [FrameSelectWidth-1:0] FrameSelect;
    logic                        FrameStrobe;
    logic                        ConfigBusy;
    logic                        ConfigError;

    modport master (
        output WriteData, WriteStrobe,
        input  FrameData, FrameStrobe_O, FrameSelect, FrameStrobe, ConfigBusy, ConfigError
    );

    modport slave (
        input  WriteData, WriteStrobe,
        output FrameData, FrameStrobe_O, FrameSelect, FrameStrobe, ConfigBusy, ConfigError
    );
endinterface

// File: rtl/config_frame_writer.sv
// Decodes the configuration word stream (sync / address / data / desync) and
// drives the broadcast frame data, column select, row strobe and write pulse.
module config_frame_writer #(
    parameter int          MaxFramesPerCol  = 20,
    parameter int          FrameSelectWidth = 5,
    parameter int          FrameBitsPerRow  = 32,
    parameter logic [31:0] SyncWord         = 32'hFAB0_FAB1,
    parameter logic [31:0] DesyncWord       = 32'hFAB0_FAB0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    config_frame_writer_if.slave  cfg_if
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_SKIP = 2'd3
    } state_e;

    state_e                      state_q, state_d;
    logic [FrameBitsPerRow-1:0]  data_q, data_d;
    logic [FrameSelectWidth-1:0] sel_q, sel_d;
    logic [MaxFramesPerCol-1:0]  row_q, row_d;
    logic                        strobe_q, strobe_d;
    logic                        error_q, error_d;

    logic [31:0]                 word;
    logic                        addr_ok;

    function automatic logic [MaxFramesPerCol-1:0] row_onehot(input logic [7:0] idx);
        logic [MaxFramesPerCol-1:0] oh;
        oh = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

    assign word    = cfg_if.WriteData;
    // Bits between the column field and the index are don't-care; only the top byte is policed.
    assign addr_ok = (word[31:24] == 8'h00) && (int'(word[7:0]) < MaxFramesPerCol);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        row_d    = row_q;
        strobe_d = 1'b0;
        error_d  = error_q;

        if (cfg_if.WriteStrobe) begin
            unique case (state_q)
                S_IDLE: begin
                    if (word == SyncWord) begin
                        state_d = S_ADDR;
                        error_d = 1'b0;
                    end
                end
                S_ADDR: begin
                    if (word == DesyncWord) begin
                        state_d = S_IDLE;
                    end else if (word == SyncWord) begin
                        state_d = S_ADDR;
                    end else if (addr_ok) begin
                        sel_d   = word[16 +: FrameSelectWidth];
                        row_d   = row_onehot(word[7:0]);
                        state_d = S_DATA;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_SKIP;
                    end
                end
                // Any value here is payload, including the sync/desync patterns.
                S_DATA: begin
                    data_d   = word[FrameBitsPerRow-1:0];
                    strobe_d = 1'b1;
                    state_d  = S_ADDR;
                end
                S_SKIP: begin
                    state_d = S_ADDR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            sel_q    <= '0;
            row_q    <= '0;
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            row_q    <= row_d;
            strobe_q <= strobe_d;
            error_q  <= error_d;
        end
    end

    assign cfg_if.FrameData     = data_q;
    assign cfg_if.FrameSelect   = sel_q;
    assign cfg_if.FrameStrobe_O = row_q;
    assign cfg_if.FrameStrobe   = strobe_q;
    assign cfg_if.ConfigError   = error_q;
    assign cfg_if.ConfigBusy    = (state_q != S_IDLE);

endmodule
